adpcm_seq: RTL and testbench
============================

Name: adpcm_seq

Overview:
- Sequencer that feeds the MSM5205-style ADPCM decoder from sample ROM.
- The CPU writes start and end page registers, then triggers playback. The block fetches bytes from ROM over a request/ack handshake and presents one nibble per sample strobe, high nibble first.
- It holds the decoder in reset while idle.
- It sits between the sound CPU bus, the SDRAM/ROM arbiter port and the decoder/timing block, whose sample-rate strobe is `sample_cen`.

Parameters:
- ADDR_W, 17: ROM byte-address width.
- PAGE_SH, 8: left shift applied to the 8-bit start/end registers to form byte addresses (256-byte pages).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active low.
- cpu_we, input, 1: one-cycle register write strobe.
- cpu_addr, input, 2: register select. 0 = start page, 1 = end page, 2 = control.
- cpu_din, input, 8: write data.
- sample_cen, input, 1: one-cycle sample-rate strobe from the decoder timing block.
- rom_addr, output, ADDR_W: ROM byte address.
- rom_cs, output, 1: fetch request; held high until `rom_ok`.
- rom_ok, input, 1: data valid for the current request; honoured only while `rom_cs` is high.
- rom_data, input, 8: ROM byte.
- adpcm_din, output, 4: nibble to the decoder.
- adpcm_rst, output, 1: decoder reset; high while idle.
- busy, output, 1: playback active.
- underrun, output, 1: sticky flag; ROM data was not ready at a byte boundary.

Behaviour:
- **Reset:** `rst_n` low asynchronously clears everything.
  - Registers: `start_reg`=0, `end_reg`=0.
  - Datapath: `ptr`=0, `buf`=0, `buf_valid`=0, `phase`=0.
  - Outputs: `rom_cs`=0, `rom_addr`=0, `adpcm_din`=0, `adpcm_rst`=1, `busy`=0, `underrun`=0.
  - State: IDLE.
- **Register writes** (`cpu_we` high):
  - Address 0 loads `start_reg`; address 1 loads `end_reg`. Both can be written at any time; changes take effect at the next trigger.
  - Address 2, `cpu_din[0]`=1 triggers playback.
    - Trigger is accepted only if `end_reg` > `start_reg` (unsigned); otherwise it is ignored.
    - On accept: `ptr` <= `start_reg`<<PAGE_SH, `end_ptr` <= `end_reg`<<PAGE_SH (exclusive bound).
    - Also clears `buf_valid`, `phase`, `underrun`, and `rom_cs`; enters FETCH. `busy` and `adpcm_rst`=0 take effect the next cycle.
    - Trigger while busy restarts cleanly; any outstanding fetch is abandoned and a late `rom_ok` is ignored.
  - Address 2, `cpu_din[0]`=0 stops playback: IDLE next cycle, `rom_cs`=0, `adpcm_rst`=1, `adpcm_din`=0.
  - A CPU write has priority over `sample_cen` and `rom_ok` in the same cycle.
- **States:** IDLE, FETCH, WAIT, PLAY.
  - IDLE: `busy`=0, `adpcm_rst`=1. Only a trigger leaves it.
  - FETCH: entered when active, `buf_valid`=0 and `ptr` != `end_ptr`.
    - Drives `rom_addr`=`ptr`, `rom_cs`=1, then moves to WAIT.
  - WAIT: hold `rom_cs`/`rom_addr` stable.
    - On `rom_ok`: `buf`<=`rom_data`, `buf_valid`<=1, `ptr`<=`ptr`+1 (ADDR_W wrap), `rom_cs`<=0, go to PLAY.
    - Ack latency is unbounded.
  - PLAY: waits for `buf` consumption; returns to FETCH when `buf_valid`=0 and `ptr` != `end_ptr`.
- **Nibble output** (every `sample_cen` while `busy`; the fetch engine runs concurrently):
  - phase 0 with `buf_valid`=1: `adpcm_din`<=`buf[7:4]`, `cur`<=`buf`, `buf_valid`<=0, `phase`<=1.
  - phase 1: `adpcm_din`<=`cur[3:0]`, `phase`<=0.
  - phase 0, `buf_valid`=0, `ptr`==`end_ptr`, no fetch outstanding: end of sample. IDLE next cycle, `adpcm_rst`=1, `adpcm_din`=0.
  - phase 0, `buf_valid`=0, otherwise: underrun. `adpcm_din`<=0, `underrun`<=1, phase stays 0 (retry next strobe).
  - `rom_ok` arriving in the same cycle as an underrun strobe: the byte is latched for the next strobe; no bypass.
- **Output timing:** `adpcm_din` changes only on the cycle after `sample_cen`, or on reset/stop/end.
- **Address wrap:** `ptr` wraps modulo 2^ADDR_W. The end compare is equality only.

Test Plan:
- **Basic playback:** start=0x01, end=0x02, trigger, ROM returns byte = address low 8 bits, `rom_ok` 3 cycles after `rom_cs`, `sample_cen` every 16 cycles.
  -> `rom_addr` 0x100..0x1FF in order; `adpcm_din` sequence 0,0,0,1,0,2,…,F,F.
  -> after 512 strobes, `busy`=0 and `adpcm_rst`=1 the next cycle; `underrun`=0.
- **Invalid trigger:** start=0x05, end=0x05 or 0x04, trigger -> `busy` stays 0, `rom_cs` never asserts.
- **Underrun:** `rom_ok` delayed 40 cycles, `sample_cen` every 16.
  -> `underrun`=1, `adpcm_din`=0 on starved strobes, and the byte plays on the first strobe after the ack; no nibble lost or repeated.
- **Stop mid-fetch:** stop write while `rom_cs`=1, then `rom_ok` pulses 2 cycles later.
  -> `rom_cs`=0 the next cycle; the late ack is ignored; IDLE, `adpcm_rst`=1, `adpcm_din`=0.
- **Retrigger while busy:** retrigger with start=0x10, end=0x11.
  -> the next fetch is at 0x1000; `underrun` cleared; phase restarts with the high nibble.
- **Async reset mid-playback:** `rst_n` low between clock edges.
  -> all outputs take their reset values immediately; playback does not resume after release.

Source files
------------

// File: rtl/adpcm_seq.sv
// adpcm_seq: ROM-to-MSM5205 nibble sequencer.
// CPU sets a page range, bytes are fetched by req/ack, high nibble first.
module adpcm_seq #(
  parameter int ADDR_W  = 17,
  parameter int PAGE_SH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_addr,
  input  logic [7:0]        cpu_din,
  input  logic              sample_cen,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  input  logic              rom_ok,
  input  logic [7:0]        rom_data,
  output logic [3:0]        adpcm_din,
  output logic              adpcm_rst,
  output logic              busy,
  output logic              underrun
);

  typedef enum logic [1:0] {
    IDLE, FETCH, WAIT, PLAY
  } state_t;

  state_t            state_q;
  logic [7:0]        start_q, end_q;
  logic [7:0]        buf_q, cur_q;
  logic [ADDR_W-1:0] ptr_q, end_ptr_q, addr_q;
  logic              buf_vld_q, phase_q;
  logic              cs_q, arst_q, busy_q, unr_q;
  logic [3:0]        din_q;

  logic ctrl_wr, go_ok, at_end;

  function automatic logic [ADDR_W-1:0] page(
    input logic [7:0] p
  );
    return ADDR_W'(p) << PAGE_SH;
  endfunction

  assign ctrl_wr = cpu_we && (cpu_addr == 2'd2);
  assign go_ok   = ctrl_wr && cpu_din[0]
                && (end_q > start_q);
  assign at_end  = (ptr_q == end_ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= '0;
      end_q     <= '0;
      buf_q     <= '0;
      cur_q     <= '0;
      ptr_q     <= '0;
      end_ptr_q <= '0;
      addr_q    <= '0;
      buf_vld_q <= 1'b0;
      phase_q   <= 1'b0;
      cs_q      <= 1'b0;
      arst_q    <= 1'b1;
      busy_q    <= 1'b0;
      unr_q     <= 1'b0;
      din_q     <= '0;
    end else begin
      if (cpu_we && cpu_addr == 2'd0)
        start_q <= cpu_din;
      if (cpu_we && cpu_addr == 2'd1)
        end_q <= cpu_din;

      if (go_ok) begin
        ptr_q     <= page(start_q);
        end_ptr_q <= page(end_q);
        buf_vld_q <= 1'b0;
        phase_q   <= 1'b0;
        unr_q     <= 1'b0;
        cs_q      <= 1'b0;
        state_q   <= FETCH;
        busy_q    <= 1'b1;
        arst_q    <= 1'b0;
      end else if (ctrl_wr && !cpu_din[0]) begin
        state_q <= IDLE;
        cs_q    <= 1'b0;
        arst_q  <= 1'b1;
        busy_q  <= 1'b0;
        din_q   <= '0;
      end else if (state_q != IDLE) begin
        unique case (state_q)
          IDLE: ;
          FETCH: begin
            addr_q  <= ptr_q;
            cs_q    <= 1'b1;
            state_q <= WAIT;
          end
          WAIT: if (rom_ok) begin
            buf_q     <= rom_data;
            buf_vld_q <= 1'b1;
            ptr_q     <= ptr_q + ADDR_W'(1);
            cs_q      <= 1'b0;
            state_q   <= PLAY;
          end
          PLAY: if (!buf_vld_q && !at_end)
            state_q <= FETCH;
        endcase

        // Nibble side; a byte acked this cycle waits for the next strobe
        if (sample_cen) begin
          if (phase_q) begin
            din_q   <= cur_q[3:0];
            phase_q <= 1'b0;
          end else if (buf_vld_q) begin
            din_q     <= buf_q[7:4];
            cur_q     <= buf_q;
            buf_vld_q <= 1'b0;
            phase_q   <= 1'b1;
          end else if (at_end && state_q == PLAY) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            arst_q  <= 1'b1;
            din_q   <= '0;
          end else begin
            din_q <= '0;
            unr_q <= 1'b1;
          end
        end
      end
    end
  end

  assign rom_addr  = addr_q;
  assign rom_cs    = cs_q;
  assign adpcm_din = din_q;
  assign adpcm_rst = arst_q;
  assign busy      = busy_q;
  assign underrun  = unr_q;

endmodule

// File: tb/tb_adpcm_seq.sv
// tb_adpcm_seq: scoreboard bench for adpcm_seq.
// ROM responder runs alongside the scenario tasks.
module tb_adpcm_seq;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_we = 1'b0;
  logic [1:0]    cpu_addr = '0;
  logic [7:0]    cpu_din = '0;
  logic          sample_cen = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic          rom_ok = 1'b0;
  logic [7:0]    rom_data = '0;
  logic [3:0]    adpcm_din;
  logic          adpcm_rst, busy, underrun;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int          ack_dly = 3;
  bit          ack_en = 1'b1;
  logic [7:0]  data_off = '0;

  typedef struct {
    logic [7:0]  b;
    int unsigned at;
  } ack_t;

  ack_t          pend[$];
  logic [3:0]    nib_q[$];
  logic [AW-1:0] adr_q[$];

  adpcm_seq #(.ADDR_W(AW), .PAGE_SH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .sample_cen(sample_cen),
    .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_ok(rom_ok), .rom_data(rom_data),
    .adpcm_din(adpcm_din), .adpcm_rst(adpcm_rst),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: ack ack_dly cycles after rom_cs rises
  initial begin : rom_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ack_en) begin
        if (rom_ok) begin
          rom_ok = 1'b0;
          cnt = 0;
        end else if (rom_cs) begin
          cnt++;
          if (cnt >= ack_dly) begin
            rom_ok = 1'b1;
            rom_data = rom_addr[7:0] + data_off;
            pend.push_back('{rom_data, cyc + 1});
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  task automatic cpu_wr(input logic [1:0] a,
                        input logic [7:0] d);
    @(negedge clk);
    sample_cen = 1'b0;
    cpu_we = 1'b1;
    cpu_addr = a;
    cpu_din = d;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic strobe();
    @(negedge clk);
    sample_cen = 1'b1;
    @(negedge clk);
    sample_cen = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] got, exp;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp = {1'b0, 17'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    got = {rom_cs, rom_addr, adpcm_din,
           adpcm_rst, busy, underrun};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h",
               got, exp);
    end
    rst_n = 1'b1;
    cpu_wr(2'd2, 8'h01);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rom_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs_trigger: busy %b cs %b expected 0 0",
               busy, rom_cs);
    end
  endtask

  task automatic test_basic();
    logic          prev_cs;
    bit            done;
    logic [AW-1:0] ea;
    logic [3:0]    en;
    ack_dly = 3;
    data_off = 8'h00;
    pend.delete();
    nib_q.delete();
    adr_q.delete();
    cpu_wr(2'd0, 8'h01);
    cpu_wr(2'd1, 8'h02);
    for (int a = 0; a < 256; a++) begin
      adr_q.push_back(AW'(32'h100 + a));
      nib_q.push_back(4'(a >> 4));
      nib_q.push_back(4'(a));
    end
    cpu_wr(2'd2, 8'h01);
    prev_cs = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 600 * 16 && !done; i++) begin
      @(negedge clk);
      if (rom_cs && !prev_cs) begin
        checks++;
        if (adr_q.size() == 0) begin
          errors++;
          $display("FAIL basic_addr: extra fetch at %h expected none",
                   rom_addr);
        end else begin
          ea = adr_q.pop_front();
          if (rom_addr !== ea) begin
            errors++;
            $display("FAIL basic_addr: got %h expected %h",
                     rom_addr, ea);
          end
        end
      end
      prev_cs = rom_cs;
      if (sample_cen) begin
        checks++;
        if (nib_q.size() > 0) begin
          en = nib_q.pop_front();
          if (adpcm_din !== en) begin
            errors++;
            $display("FAIL basic_nibble: got %h expected %h",
                     adpcm_din, en);
          end
        end else begin
          done = 1'b1;
          if (busy !== 1'b0 || adpcm_rst !== 1'b1 ||
              adpcm_din !== 4'h0) begin
            errors++;
            $display("FAIL basic_end: busy %b rst %b din %h expected 0 1 0",
                     busy, adpcm_rst, adpcm_din);
          end
        end
      end
      sample_cen = (i % 16 == 15);
    end
    sample_cen = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL basic_timeout: %0d nibbles left expected 0",
               nib_q.size());
    end
    checks++;
    if (adr_q.size() != 0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_tail: addrs left %0d underrun %b expected 0 0",
               adr_q.size(), underrun);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] ends [2];
    bit seen;
    ends[0] = 8'h05;
    ends[1] = 8'h04;
    for (int k = 0; k < 2; k++) begin
      cpu_wr(2'd0, 8'h05);
      cpu_wr(2'd1, ends[k]);
      cpu_wr(2'd2, 8'h01);
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (busy !== 1'b0 || rom_cs !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL invalid_trigger: end %h started, expected ignored",
                 ends[k]);
      end
    end
  endtask

  task automatic test_underrun();
    bit         ph;
    logic [7:0] cur;
    logic [3:0] ex;
    int         starved, played;
    ack_t       t;
    ack_dly = 40;
    data_off = 8'h5A;
    cpu_wr(2'd0, 8'h03);
    cpu_wr(2'd1, 8'h04);
    cpu_wr(2'd2, 8'h01);
    pend.delete();
    ph = 1'b0;
    cur = '0;
    starved = 0;
    played = 0;
    for (int i = 0; i < 16 * 12; i++) begin
      @(negedge clk);
      if (sample_cen) begin
        checks++;
        if (ph) begin
          ex = cur[3:0];
          ph = 1'b0;
          played++;
        end else if (pend.size() > 0 && pend[0].at < cyc) begin
          t = pend.pop_front();
          cur = t.b;
          ex = cur[7:4];
          ph = 1'b1;
          played++;
        end else begin
          ex = 4'h0;
          starved++;
        end
        if (adpcm_din !== ex) begin
          errors++;
          $display("FAIL underrun_nibble: got %h expected %h",
                   adpcm_din, ex);
        end
      end
      sample_cen = (i % 16 == 15);
    end
    sample_cen = 1'b0;
    checks++;
    if (underrun !== 1'b1 || starved == 0 || played < 4) begin
      errors++;
      $display("FAIL underrun_flag: flag %b starved %0d played %0d expected 1 >0 >=4",
               underrun, starved, played);
    end
    cpu_wr(2'd2, 8'h00);
  endtask

  task automatic test_stop();
    ack_en = 1'b0;
    rom_ok = 1'b0;
    cpu_wr(2'd0, 8'h06);
    cpu_wr(2'd1, 8'h07);
    cpu_wr(2'd2, 8'h01);
    for (int n = 0; n < 20 && !rom_cs; n++) @(negedge clk);
    checks++;
    if (rom_cs !== 1'b1) begin
      errors++;
      $display("FAIL stop_fetch_timeout: cs %b expected 1", rom_cs);
    end
    cpu_wr(2'd2, 8'h00);
    checks++;
    if (rom_cs !== 1'b0 || busy !== 1'b0 ||
        adpcm_rst !== 1'b1 || adpcm_din !== 4'h0) begin
      errors++;
      $display("FAIL stop_now: cs %b busy %b rst %b din %h expected 0 0 1 0",
               rom_cs, busy, adpcm_rst, adpcm_din);
    end
    @(negedge clk);
    rom_ok = 1'b1;
    rom_data = 8'hFF;
    @(negedge clk);
    rom_ok = 1'b0;
    strobe();
    repeat (3) @(negedge clk);
    checks++;
    if (rom_cs !== 1'b0 || busy !== 1'b0 ||
        adpcm_rst !== 1'b1 || adpcm_din !== 4'h0) begin
      errors++;
      $display("FAIL stop_late_ack: cs %b busy %b rst %b din %h expected 0 0 1 0",
               rom_cs, busy, adpcm_rst, adpcm_din);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_retrigger();
    logic [7:0] eb;
    ack_t       t;
    ack_dly = 40;
    data_off = 8'h5A;
    cpu_wr(2'd0, 8'h03);
    cpu_wr(2'd1, 8'h05);
    cpu_wr(2'd2, 8'h01);
    pend.delete();
    repeat (10) @(negedge clk);
    strobe();
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL retrig_pre_underrun: got %b expected 1", underrun);
    end
    for (int n = 0; n < 100 && pend.size() == 0; n++)
      @(negedge clk);
    checks++;
    if (pend.size() == 0) begin
      errors++;
      $display("FAIL retrig_ack_timeout: acks 0 expected 1");
    end else begin
      t = pend.pop_front();
      strobe();
      checks++;
      if (adpcm_din !== t.b[7:4]) begin
        errors++;
        $display("FAIL retrig_pre_nibble: got %h expected %h",
                 adpcm_din, t.b[7:4]);
      end
    end
    ack_dly = 3;
    cpu_wr(2'd0, 8'h10);
    cpu_wr(2'd1, 8'h11);
    cpu_wr(2'd2, 8'h01);
    pend.delete();
    checks++;
    if (underrun !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL retrig_state: underrun %b busy %b expected 0 1",
               underrun, busy);
    end
    for (int n = 0; n < 20 && !rom_cs; n++) @(negedge clk);
    checks++;
    if (rom_cs !== 1'b1 || rom_addr !== 17'h1000) begin
      errors++;
      $display("FAIL retrig_addr: cs %b addr %h expected 1 1000",
               rom_cs, rom_addr);
    end
    for (int n = 0; n < 20 && pend.size() == 0; n++)
      @(negedge clk);
    eb = 8'h00 + data_off;
    strobe();
    checks++;
    if (adpcm_din !== eb[7:4]) begin
      errors++;
      $display("FAIL retrig_high: got %h expected %h",
               adpcm_din, eb[7:4]);
    end
    strobe();
    checks++;
    if (adpcm_din !== eb[3:0]) begin
      errors++;
      $display("FAIL retrig_low: got %h expected %h",
               adpcm_din, eb[3:0]);
    end
    cpu_wr(2'd2, 8'h00);
  endtask

  task automatic test_async_reset();
    logic [24:0] got, exp;
    bit seen;
    ack_dly = 40;
    data_off = 8'h5A;
    cpu_wr(2'd0, 8'h01);
    cpu_wr(2'd1, 8'h02);
    cpu_wr(2'd2, 8'h01);
    repeat (5) @(negedge clk);
    strobe();
    for (int n = 0; n < 20 && !rom_cs; n++) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || underrun !== 1'b1 || rom_cs !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: busy %b unr %b cs %b expected 1 1 1",
               busy, underrun, rom_cs);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp = {1'b0, 17'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    got = {rom_cs, rom_addr, adpcm_din,
           adpcm_rst, busy, underrun};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL areset_immediate: got %h expected %h",
               got, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || rom_cs !== 1'b0 ||
          adpcm_rst !== 1'b1) seen = 1'b1;
      sample_cen = (i % 16 == 15);
    end
    sample_cen = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL areset_resume: playback resumed, expected idle");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_underrun();
    test_stop();
    test_retrigger();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
